// File: rtl/steak_scorer.sv
// Grades served steaks against the held customer order and keeps score, strikes and game-over state.
// State | meaning
// S_IDLE   | waiting for an order and a serve edge
// S_EVAL   | grading the snapshotted doneness against the target
// S_UPDATE | committing score/strikes and pulsing result_valid/steak_clear
module steak_scorer #(
    parameter int unsigned POINTS_EXACT = 10,
    parameter int unsigned POINTS_NEAR  = 5,
    parameter int unsigned POINTS_FAR   = 2,
    parameter int unsigned MAX_STRIKES  = 3,
    parameter int unsigned SCORE_MAX    = 999
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] steak_state,
    input  logic       serve,
    input  logic       order_valid,
    input  logic [2:0] order_target,
    output logic       order_ready,
    output logic [9:0] score,
    output logic [3:0] last_points,
    output logic [2:0] strikes,
    output logic       game_over,
    output logic       result_valid,
    output logic       steak_clear,
    output logic       serve_reject
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EVAL   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [2:0]  STRIKE_LIMIT = 3'(MAX_STRIKES);
    localparam logic [10:0] SCORE_CAP    = 11'(SCORE_MAX);

    logic [1:0]  state;
    logic        serve_q;
    logic        order_held;
    logic [2:0]  target;
    logic [2:0]  snap;
    logic [2:0]  snap_target;
    logic [3:0]  pts;
    logic        strike_hit;
    logic        reject_pend;

    logic        serve_edge;
    logic [2:0]  target_clamped;
    logic [2:0]  diff;
    logic [3:0]  pts_c;
    logic        burnt_or_raw;
    logic [10:0] score_sum;
    logic [9:0]  score_next;
    logic [2:0]  strikes_inc;

    assign serve_edge  = serve && !serve_q;
    assign order_ready = !order_held && !game_over && (state == S_IDLE);

    always_comb begin
        target_clamped = order_target;
        if (order_target < 3'd2)
            target_clamped = 3'd2;
        else if (order_target > 3'd6)
            target_clamped = 3'd6;
    end

    always_comb begin
        diff         = (snap >= snap_target) ? (snap - snap_target) : (snap_target - snap);
        burnt_or_raw = (snap == 3'd1) || (snap == 3'd7);
        pts_c        = 4'd0;
        if (!burnt_or_raw) begin
            case (diff)
                3'd0:    pts_c = 4'(POINTS_EXACT);
                3'd1:    pts_c = 4'(POINTS_NEAR);
                3'd2:    pts_c = 4'(POINTS_FAR);
                default: pts_c = 4'd0;
            endcase
        end
    end

    // Sum is widened to 11 bits so a near-ceiling score cannot wrap before saturating.
    always_comb begin
        score_sum   = {1'b0, score} + {7'd0, pts};
        score_next  = (score_sum > SCORE_CAP) ? SCORE_CAP[9:0] : score_sum[9:0];
        strikes_inc = strikes + 3'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            serve_q      <= 1'b0;
            order_held   <= 1'b0;
            target       <= 3'd2;
            snap         <= 3'd0;
            snap_target  <= 3'd2;
            pts          <= 4'd0;
            strike_hit   <= 1'b0;
            reject_pend  <= 1'b0;
            score        <= 10'd0;
            last_points  <= 4'd0;
            strikes      <= 3'd0;
            game_over    <= 1'b0;
            result_valid <= 1'b0;
            steak_clear  <= 1'b0;
            serve_reject <= 1'b0;
        end else begin
            serve_q      <= serve;
            result_valid <= 1'b0;
            steak_clear  <= 1'b0;
            reject_pend  <= 1'b0;
            serve_reject <= reject_pend;
            case (state)
                S_IDLE: begin
                    if (order_valid && order_ready) begin
                        target     <= target_clamped;
                        order_held <= 1'b1;
                    end
                    if (serve_edge) begin
                        if (!game_over && order_held && (steak_state != 3'd0)) begin
                            snap        <= steak_state;
                            snap_target <= target;
                            state       <= S_EVAL;
                        end else begin
                            reject_pend <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    pts        <= pts_c;
                    strike_hit <= burnt_or_raw;
                    state      <= S_UPDATE;
                end
                S_UPDATE: begin
                    score       <= score_next;
                    last_points <= pts;
                    if (strike_hit && (strikes < STRIKE_LIMIT)) begin
                        strikes <= strikes_inc;
                        if (strikes_inc == STRIKE_LIMIT)
                            game_over <= 1'b1;
                    end
                    result_valid <= 1'b1;
                    steak_clear  <= 1'b1;
                    order_held   <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_steak_scorer.sv
// Directed bench for steak_scorer: grading, saturation, strikes, rejects and mid-evaluation reset.
module tb_steak_scorer;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] steak_state;
    logic       serve;
    logic       order_valid;
    logic [2:0] order_target;
    logic       order_ready;
    logic [9:0] score;
    logic [3:0] last_points;
    logic [2:0] strikes;
    logic       game_over;
    logic       result_valid;
    logic       steak_clear;
    logic       serve_reject;

    int n_assert = 0;
    int n_fail   = 0;
    int rv_count;
    int rj_count;

    steak_scorer dut (
        .clock        (clock),
        .resetn       (resetn),
        .steak_state  (steak_state),
        .serve        (serve),
        .order_valid  (order_valid),
        .order_target (order_target),
        .order_ready  (order_ready),
        .score        (score),
        .last_points  (last_points),
        .strikes      (strikes),
        .game_over    (game_over),
        .result_valid (result_valid),
        .steak_clear  (steak_clear),
        .serve_reject (serve_reject)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        serve = 1'b0;
        order_valid = 1'b0;
        order_target = 3'd0;
        steak_state = 3'd0;
        #3;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic give_order(input logic [2:0] t);
        order_valid  = 1'b1;
        order_target = t;
        tick();
        order_valid = 1'b0;
    endtask

    // Leaves time just after edge N+2, where result_valid should be high.
    task automatic run_serve(input logic [2:0] t, input logic [2:0] s);
        give_order(t);
        steak_state = s;
        serve = 1'b1;
        tick();
        serve = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_reject(input string tag);
        serve = 1'b1;
        tick();
        serve = 1'b0;
        chk({tag, "_rej_early"}, serve_reject, 0);
        tick();
        chk({tag, "_rej_n1"}, serve_reject, 1);
        tick();
        chk({tag, "_rej_fall"}, serve_reject, 0);
        chk({tag, "_rej_no_rv"}, result_valid, 0);
        chk({tag, "_rej_no_clear"}, steak_clear, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_score", score, 0);
        chk("rst_last", last_points, 0);
        chk("rst_strikes", strikes, 0);
        chk("rst_go", game_over, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_clear", steak_clear, 0);
        chk("rst_reject", serve_reject, 0);
        chk("rst_ready", order_ready, 1);

        // Test 1: exact match with timing, steak_state changed after snapshot
        give_order(3'd4);
        chk("t1_ready_held", order_ready, 0);
        steak_state = 3'd4;
        serve = 1'b1;
        tick();
        serve = 1'b0;
        steak_state = 3'd7;
        chk("t1_rv_n", result_valid, 0);
        tick();
        chk("t1_rv_n1", result_valid, 0);
        chk("t1_ready_busy", order_ready, 0);
        tick();
        chk("t1_rv_n2", result_valid, 1);
        chk("t1_clear_n2", steak_clear, 1);
        chk("t1_score", score, 10);
        chk("t1_last", last_points, 10);
        chk("t1_strikes", strikes, 0);
        tick();
        chk("t1_rv_n3", result_valid, 0);
        chk("t1_clear_n3", steak_clear, 0);
        chk("t1_ready_n3", order_ready, 1);

        // Test 2: far and near
        do_reset();
        run_serve(3'd3, 3'd5);
        chk("t2_far_last", last_points, 2);
        chk("t2_far_score", score, 2);
        run_serve(3'd6, 3'd5);
        chk("t2_near_last", last_points, 5);
        chk("t2_score", score, 7);
        chk("t2_strikes", strikes, 0);
        run_serve(3'd2, 3'd6);
        chk("t2_diff4_last", last_points, 0);
        chk("t2_diff4_score", score, 7);

        // Test 3: burnt strikes to game over, raw counts too
        run_serve(3'd4, 3'd7);
        chk("t3_s1", strikes, 1);
        chk("t3_s1_pts", last_points, 0);
        run_serve(3'd2, 3'd1);
        chk("t3_s2", strikes, 2);
        chk("t3_s2_go", game_over, 0);
        run_serve(3'd6, 3'd7);
        chk("t3_s3", strikes, 3);
        chk("t3_go_rv", result_valid, 1);
        chk("t3_go", game_over, 1);
        chk("t3_score", score, 7);
        tick();
        chk("t3_ready_go", order_ready, 0);
        give_order(3'd4);
        steak_state = 3'd4;
        run_reject("t3_post_go");
        chk("t3_score_after", score, 7);
        chk("t3_strikes_after", strikes, 3);
        chk("t3_go_sticky", game_over, 1);

        // Test 4: rejects and long serve hold
        do_reset();
        steak_state = 3'd4;
        run_reject("t4_no_order");
        give_order(3'd4);
        steak_state = 3'd0;
        run_reject("t4_empty");
        chk("t4_score", score, 0);
        chk("t4_order_kept", order_ready, 0);
        steak_state = 3'd4;
        serve = 1'b1;
        rv_count = 0;
        rj_count = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid) rv_count++;
            if (serve_reject) rj_count++;
        end
        serve = 1'b0;
        tick();
        if (result_valid) rv_count++;
        if (serve_reject) rj_count++;
        chk("t4_hold_grades", rv_count, 1);
        chk("t4_hold_rejects", rj_count, 0);
        chk("t4_hold_score", score, 10);

        // Test 5: saturation at 999
        do_reset();
        for (int i = 0; i < 99; i++) run_serve(3'd5, 3'd5);
        chk("t5_990", score, 990);
        run_serve(3'd5, 3'd4);
        chk("t5_995", score, 995);
        run_serve(3'd3, 3'd3);
        chk("t5_sat", score, 999);
        chk("t5_last", last_points, 10);
        run_serve(3'd3, 3'd3);
        chk("t5_sat_hold", score, 999);

        // Test 6: reset during evaluation, then clamped orders
        do_reset();
        run_serve(3'd4, 3'd4);
        chk("t6_pre", score, 10);
        give_order(3'd4);
        steak_state = 3'd4;
        serve = 1'b1;
        tick();
        serve = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t6_rst_score", score, 0);
        chk("t6_rst_last", last_points, 0);
        chk("t6_rst_rv", result_valid, 0);
        tick();
        resetn = 1'b1;
        rv_count = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (result_valid) rv_count++;
        end
        chk("t6_no_rv", rv_count, 0);
        chk("t6_ready", order_ready, 1);
        run_serve(3'd7, 3'd6);
        chk("t6_clamp_hi", last_points, 10);
        run_serve(3'd0, 3'd2);
        chk("t6_clamp_lo", last_points, 10);
        chk("t6_score", score, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
